tx_arb_p: RTL and testbench
===========================

Name: tx_arb_p

Overview:
- Round-robin arbiter that shares one two-phase (transition-signalling) output channel between PORTS local requesters.
- Sits between router-side sources (e.g. crossbar outputs or injection queues) and a single tx_p instance: its output channel drives tx_p's req1/data1, and takes tx_p's ack1 as ack_out.
- Serialises one transfer at a time. Forwards the downstream acknowledge back to the granted requester only.
- Fully synchronous to clk; all inputs are sampled on the rising edge.

Parameters:
- PORTS, 4, number of requester channels (2..8).
- SIZE, 8, data width per channel (matches the global `SIZE).
- GW, 2, width of the grant index; must satisfy 2^GW >= PORTS.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_in  input  PORTS  per-port two-phase request; port i is pending while req_in[i] != ack_in[i].
- ack_in  output  PORTS  per-port two-phase acknowledge; toggles once per completed transfer.
- data_in  input  PORTS*SIZE  port i data at bits [i*SIZE +: SIZE]; held stable by the source while port i is pending.
- req_out  output  1  two-phase request to the downstream tx.
- ack_out  input  1  two-phase acknowledge from the downstream tx.
- data_out  output  SIZE  registered data of the granted port.
- grant  output  GW  index of the last/current granted port.
- busy  output  1  high while a downstream transfer is outstanding.

Behaviour:
- Reset (async, immediate):
  - req_out=0, ack_in=0, data_out=0, grant=PORTS-1, busy=0, state=IDLE.
  - Internal last-grant pointer = PORTS-1, so port 0 has first priority.
  - Reset mid-transfer abandons the transfer; the surrounding system resets together.
- pending[i] = req_in[i] ^ ack_in[i]. out_pending = req_out ^ ack_out.
- States: IDLE, BUSY. busy=1 exactly in BUSY.
- IDLE, at a clock edge where any pending[i] is set:
  - Select the first pending port scanning last+1, last+2, ... modulo PORTS.
  - data_out <= data_in[sel], req_out <= ~req_out, grant <= sel, state <= BUSY.
  - Latency: req_out toggles on the same edge the pending request is sampled (1 edge from the req_in transition being visible).
- IDLE with no pending port: hold all outputs.
- BUSY, at an edge where out_pending==0 (ack_out has matched req_out):
  - ack_in[grant] <= ~ack_in[grant], last <= grant, state <= IDLE.
  - The next grant is issued no earlier than the following edge. Minimum spacing between successive req_out toggles is 2 cycles plus the downstream ack delay.
- BUSY otherwise: hold. data_out, req_out and grant are stable for the whole transfer.
- In BUSY, req_in changes on non-granted ports are only recorded as pending; they do not disturb the current transfer.
- Fairness: a port that is continuously pending is granted within PORTS transfers. The just-served port has lowest priority.
- Simultaneous requests: resolved purely by the round-robin scan; the pointer advances only on completion.
- Wrap-around: the scan from last=PORTS-1 starts at port 0. With PORTS not a power of two, indices >= PORTS are never selected.
- Protocol violations are unsupported, and the bench must not generate them:
  - a second req_in toggle before the matching ack_in;
  - an ack_out toggle while IDLE.
  - On an IDLE ack_out toggle the block changes no output; it then treats out_pending as set. This case is not tested beyond "no ack_in toggle".
- data_in[grant] is only required to be stable at the granting edge, since data_out is a register.

Test Plan:
- Reset then single request:
  - Stimulus: reset; toggle req_in[2] with data 0xA5; downstream acks 3 cycles after req_out toggles.
  - Required: req_out 0->1 and data_out=0xA5 at the first edge; grant=2, busy=1; ack_in[2] toggles 1 edge after ack_out toggles; busy=0.
- Simultaneous requests:
  - Stimulus: all four ports toggle req together with data 0x10, 0x11, 0x12, 0x13; downstream ack is immediate.
  - Required: grants in order 0,1,2,3; data_out 0x10..0x13; each ack_in toggles exactly once; req_out toggles 4 times.
- Fairness / wrap:
  - Stimulus: port 3 and port 0 continuously re-request; last=3.
  - Required: port 0 granted next, then port 3, alternating; never two consecutive grants to one port while the other is pending.
- Stall:
  - Stimulus: hold ack_out for 20 cycles while ports 1 and 2 toggle req.
  - Required: req_out, data_out and grant stay constant and no ack_in toggles during the stall; after ack, grant proceeds round-robin.
- Reset mid-transfer:
  - Stimulus: assert reset while BUSY with req_out=1.
  - Required: req_out, ack_in and data_out go to 0, grant=PORTS-1 and busy=0 immediately, without waiting for a clock edge.
- Second-phase polarity:
  - Stimulus: two back-to-back transfers on port 1.
  - Required: req_out goes 0->1 then 1->0; ack_in[1] goes 0->1 then 1->0; transfers are counted on toggles, not levels.

Source files
------------

// File: rtl/tx_arb_p.sv
// Round-robin arbiter sharing one two-phase (transition-signalled) output
// channel between PORTS local requesters; one transfer in flight at a time.
module tx_arb_p #(
  parameter int PORTS = 4,
  parameter int SIZE  = 8,
  parameter int GW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORTS-1:0]      req_in,
  output logic [PORTS-1:0]      ack_in,
  input  logic [PORTS*SIZE-1:0] data_in,
  output logic                  req_out,
  input  logic                  ack_out,
  output logic [SIZE-1:0]       data_out,
  output logic [GW-1:0]         grant,
  output logic                  busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [GW-1:0] LAST_PORT = GW'(PORTS - 1);

  state_t           state_q, state_d;
  logic             req_out_q, req_out_d;
  logic [PORTS-1:0] ack_in_q, ack_in_d;
  logic [SIZE-1:0]  data_out_q, data_out_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;

  logic [PORTS-1:0] pending;
  logic             out_pending;
  logic             found;
  logic [GW-1:0]    sel;

  // Handshake: a channel is pending while its req and ack levels differ;
  // every completed transfer is one toggle of req followed by one of ack.
  assign pending     = req_in ^ ack_in_q;
  assign out_pending = req_out_q ^ ack_out;

  // Scan starts just after the last served port, so it gets lowest priority.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      if (!found && pending[(int'(last_q) + k) % PORTS]) begin
        found = 1'b1;
        sel   = GW'((int'(last_q) + k) % PORTS);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_out_d  = req_out_q;
    ack_in_d   = ack_in_q;
    data_out_d = data_out_q;
    grant_d    = grant_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          data_out_d = data_in[int'(sel)*SIZE +: SIZE];
          req_out_d  = ~req_out_q;
          grant_d    = sel;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // The pointer only advances once the downstream ack has come back.
        if (!out_pending) begin
          ack_in_d[grant_q] = ~ack_in_q[grant_q];
          last_d            = grant_q;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_out_q  <= 1'b0;
      ack_in_q   <= '0;
      data_out_q <= '0;
      grant_q    <= LAST_PORT;
      last_q     <= LAST_PORT;
    end else begin
      state_q    <= state_d;
      req_out_q  <= req_out_d;
      ack_in_q   <= ack_in_d;
      data_out_q <= data_out_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end

  assign req_out  = req_out_q;
  assign ack_in   = ack_in_q;
  assign data_out = data_out_q;
  assign grant    = grant_q;
  assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_tx_arb_p.sv
// Directed bench for tx_arb_p: reset, single and simultaneous requests,
// fairness wrap, downstream stall, async reset mid-transfer, phase polarity.
module tb_tx_arb_p;

  localparam int PORTS = 4;
  localparam int SIZE  = 8;
  localparam int GW    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PORTS-1:0]      req_in;
  logic [PORTS-1:0]      ack_in;
  logic [PORTS*SIZE-1:0] data_in;
  logic                  req_out;
  logic                  ack_out;
  logic [SIZE-1:0]       data_out;
  logic [GW-1:0]         grant;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  logic [SIZE-1:0]  exp_q[$];
  logic [SIZE-1:0]  exp_d;
  logic [PORTS-1:0] exp_ack;
  logic             exp_req;
  int               exp_g;
  logic [SIZE-1:0]  hold_data;
  logic [GW-1:0]    hold_grant;
  int               stall_bad;

  tx_arb_p #(.PORTS(PORTS), .SIZE(SIZE), .GW(GW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_in  (data_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .data_out (data_out),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_in  = '0;
    ack_out = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    exp_ack = '0;
    exp_req = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    req_in  = '0;
    ack_out = 1'b0;
    data_in = '0;
    #1;
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_ack_in", 32'(ack_in), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single request on port 2, downstream ack a few cycles later.
    data_in[2*SIZE +: SIZE] = 8'hA5;
    req_in[2] = 1'b1;
    tick();
    chk("t1_req_out", 32'(req_out), 32'd1);
    chk("t1_data", 32'(data_out), 32'hA5);
    chk("t1_grant", 32'(grant), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("t1_hold_ack", 32'(ack_in), 32'd0);
    chk("t1_hold_busy", 32'(busy), 32'd1);
    ack_out = 1'b1;
    tick();
    chk("t1_ack_in", 32'(ack_in), 32'b0100);
    chk("t1_idle", 32'(busy), 32'd0);

    // Simultaneous requests from a fresh pointer: grants 0,1,2,3.
    do_reset();
    for (int i = 0; i < PORTS; i++) begin
      data_in[i*SIZE +: SIZE] = SIZE'(8'h10 + i);
      exp_q.push_back(SIZE'(8'h10 + i));
    end
    req_in = 4'b1111;
    for (int i = 0; i < PORTS; i++) begin
      exp_d   = exp_q.pop_front();
      exp_req = ~exp_req;
      tick();
      chk("t2_grant", 32'(grant), 32'(i));
      chk("t2_data", 32'(data_out), 32'(exp_d));
      chk("t2_req_out", 32'(req_out), 32'(exp_req));
      chk("t2_ack_hold", 32'(ack_in), 32'(exp_ack));
      ack_out = exp_req;
      tick();
      exp_ack[i] = ~exp_ack[i];
      chk("t2_ack_in", 32'(ack_in), 32'(exp_ack));
      chk("t2_busy", 32'(busy), 32'd0);
    end
    chk("t2_req_final", 32'(req_out), 32'd0);

    // Ports 0 and 3 keep re-requesting with last=3: expect 0,3,0,3.
    req_in[0] = ~req_in[0];
    req_in[3] = ~req_in[3];
    for (int i = 0; i < 4; i++) begin
      exp_g   = (i % 2 == 0) ? 0 : 3;
      exp_req = ~exp_req;
      tick();
      chk("t3_grant", 32'(grant), 32'(exp_g));
      chk("t3_req_out", 32'(req_out), 32'(exp_req));
      ack_out = exp_req;
      tick();
      exp_ack[exp_g] = ~exp_ack[exp_g];
      chk("t3_ack_in", 32'(ack_in), 32'(exp_ack));
      if (i < 2) req_in[exp_g] = ~req_in[exp_g];
    end

    // Downstream stall for 20 cycles with ports 1 and 2 pending.
    data_in[1*SIZE +: SIZE] = 8'h21;
    data_in[2*SIZE +: SIZE] = 8'h22;
    req_in[1] = ~req_in[1];
    req_in[2] = ~req_in[2];
    exp_req = ~exp_req;
    tick();
    chk("t4_grant", 32'(grant), 32'd1);
    chk("t4_data", 32'(data_out), 32'h21);
    chk("t4_req_out", 32'(req_out), 32'(exp_req));
    hold_data  = 8'h21;
    hold_grant = 2'd1;
    stall_bad  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_out !== exp_req || data_out !== hold_data || grant !== hold_grant ||
          ack_in !== exp_ack || busy !== 1'b1) stall_bad++;
    end
    chk("t4_stall_stable", 32'(stall_bad), 32'd0);
    ack_out = exp_req;
    tick();
    exp_ack[1] = ~exp_ack[1];
    chk("t4_ack1", 32'(ack_in), 32'(exp_ack));
    exp_req = ~exp_req;
    tick();
    chk("t4_grant2", 32'(grant), 32'd2);
    chk("t4_data2", 32'(data_out), 32'h22);
    chk("t4_req_out2", 32'(req_out), 32'(exp_req));
    ack_out = exp_req;
    tick();
    exp_ack[2] = ~exp_ack[2];
    chk("t4_ack2", 32'(ack_in), 32'(exp_ack));

    // Two back-to-back transfers on port 1: both phases of each signal.
    do_reset();
    data_in[1*SIZE +: SIZE] = 8'h31;
    req_in[1] = 1'b1;
    tick();
    chk("t5_req_rise", 32'(req_out), 32'd1);
    chk("t5_data1", 32'(data_out), 32'h31);
    ack_out = 1'b1;
    tick();
    chk("t5_ack_rise", 32'(ack_in), 32'b0010);
    data_in[1*SIZE +: SIZE] = 8'h32;
    req_in[1] = 1'b0;
    tick();
    chk("t5_req_fall", 32'(req_out), 32'd0);
    chk("t5_grant", 32'(grant), 32'd1);
    chk("t5_data2", 32'(data_out), 32'h32);
    chk("t5_busy", 32'(busy), 32'd1);
    ack_out = 1'b0;
    tick();
    chk("t5_ack_fall", 32'(ack_in), 32'b0000);
    chk("t5_idle", 32'(busy), 32'd0);

    // Asynchronous reset while BUSY with req_out=1, away from any edge.
    data_in[3*SIZE +: SIZE] = 8'h44;
    req_in[3] = 1'b1;
    tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_req_pre", 32'(req_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_out", 32'(req_out), 32'd0);
    chk("t6_ack_in", 32'(ack_in), 32'd0);
    chk("t6_data", 32'(data_out), 32'd0);
    chk("t6_grant", 32'(grant), 32'd3);
    chk("t6_busy", 32'(busy), 32'd0);
    req_in = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_after_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
